// File: rtl/tx_cb_arb_pkg.sv
// Shared types and round-robin helper for the TX bonded-link packet arbiter.
// Pure declarations; no storage, no latency.
// No flow control; used by the arbiter FSM and candidate search.
package tx_cb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_SRC = 16;

    // First requester at or after ptr, wrapping modulo n; returns ptr when nothing requests.
    function automatic logic [3:0] rr_next(input logic [3:0] ptr,
                                           input logic [MAX_SRC-1:0] req,
                                           input int n);
        logic [3:0] r;
        int         idx;
        r = ptr;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[3:0]]) r = idx[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_cb_skid.sv
// Two-entry AXI-Stream register slice carrying {tdata, tkeep, tlast, tdest}.
// Latency: one cycle from accept to m_axis_* (registered head entry).
// Backpressure: can_accept comes from registered occupancy only, never from m_axis_tready.
module tx_cb_skid #(
    parameter int DWIDTH = 240,
    parameter int SRC_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                beat_vld,
    input  logic [DWIDTH-1:0]   beat_tdata,
    input  logic [DWIDTH/8-1:0] beat_tkeep,
    input  logic                beat_tlast,
    input  logic [SRC_W-1:0]    beat_tdest,
    output logic                can_accept,
    output logic                m_axis_tvalid,
    output logic [DWIDTH-1:0]   m_axis_tdata,
    output logic [DWIDTH/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [SRC_W-1:0]    m_axis_tdest,
    input  logic                m_axis_tready
);

    typedef struct packed {
        logic [DWIDTH-1:0]   tdata;
        logic [DWIDTH/8-1:0] tkeep;
        logic                tlast;
        logic [SRC_W-1:0]    tdest;
    } beat_t;

    beat_t      head;
    beat_t      tail;
    beat_t      in_beat;
    logic [1:0] count;
    logic       enq;
    logic       deq;

    assign in_beat       = {beat_tdata, beat_tkeep, beat_tlast, beat_tdest};
    // Held low during reset so no source sees ready while the arbiter is being cleared.
    assign can_accept    = !rst && (count != 2'd2);
    assign m_axis_tvalid = (count != 2'd0);
    assign enq           = beat_vld && can_accept;
    assign deq           = m_axis_tvalid && m_axis_tready;

    assign m_axis_tdata  = head.tdata;
    assign m_axis_tkeep  = head.tkeep;
    assign m_axis_tlast  = head.tlast;
    assign m_axis_tdest  = head.tdest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (enq) begin
                        head  <= in_beat;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (enq && deq) begin
                        head <= in_beat;
                    end else if (enq) begin
                        tail  <= in_beat;
                        count <= 2'd2;
                    end else if (deq) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (deq) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/tx_cb_pkt_arbiter.sv
// Packet-level round-robin arbiter feeding the bonded TX link; tags beats with source index.
// Latency: one cycle, accept to m_axis_* through a two-entry skid buffer.
// Backpressure: s_axis_tready follows registered buffer occupancy; m_axis_tready never reaches it.
module tx_cb_pkt_arbiter
    import tx_cb_arb_pkg::*;
#(
    parameter int  DWIDTH = 240,
    parameter int  N_SRC  = 4,
    localparam int SRC_W  = $clog2(N_SRC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DWIDTH-1:0]   s_axis_tdata [N_SRC-1:0],
    input  logic [DWIDTH/8-1:0] s_axis_tkeep [N_SRC-1:0],
    input  logic [N_SRC-1:0]    s_axis_tlast,
    input  logic [N_SRC-1:0]    s_axis_tvalid,
    output logic [N_SRC-1:0]    s_axis_tready,
    output logic [DWIDTH-1:0]   m_axis_tdata,
    output logic [DWIDTH/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [SRC_W-1:0]    m_axis_tdest,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                busy
);

    arb_state_t       state;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] cand;
    logic [SRC_W-1:0] sel;
    logic [3:0]       cand4;
    logic             any_req;
    logic             sel_ok;
    logic             can_accept;
    logic             xfer;
    logic             sel_last;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] p);
        return (p == SRC_W'(N_SRC - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cand4    = rr_next(4'(rr_ptr), 16'(s_axis_tvalid), N_SRC);
    assign cand     = cand4[SRC_W-1:0];
    assign any_req  = |s_axis_tvalid;
    assign sel      = (state == LOCKED) ? grant : cand;
    // In LOCKED the granted source owns the path even while its tvalid is low.
    assign sel_ok   = (state == LOCKED) || any_req;
    assign xfer     = sel_ok && can_accept && s_axis_tvalid[sel];
    assign sel_last = s_axis_tlast[sel];
    assign busy     = (state == LOCKED);

    always_comb begin
        s_axis_tready = '0;
        if (sel_ok && can_accept) s_axis_tready[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (sel_last) begin
                            rr_ptr <= wrap_inc(cand);
                        end else begin
                            grant <= cand;
                            state <= LOCKED;
                        end
                    end
                end
                default: begin
                    if (xfer && sel_last) begin
                        rr_ptr <= wrap_inc(grant);
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    tx_cb_skid #(
        .DWIDTH (DWIDTH),
        .SRC_W  (SRC_W)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .beat_vld      (xfer),
        .beat_tdata    (s_axis_tdata[sel]),
        .beat_tkeep    (s_axis_tkeep[sel]),
        .beat_tlast    (sel_last),
        .beat_tdest    (sel),
        .can_accept    (can_accept),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_tx_cb_pkt_arbiter.sv
// Bench for tx_cb_pkt_arbiter: arbitration vector table plus packet scenarios checked through a beat scoreboard.
module tb_tx_cb_pkt_arbiter;

    localparam int DW = 240;
    localparam int NS = 4;
    localparam int KW = DW / 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata [NS-1:0];
    logic [KW-1:0] s_tkeep [NS-1:0];
    logic [NS-1:0] s_tlast, s_tvalid, s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [SW-1:0] m_tdest;
    logic          m_tvalid, m_tready, busy;

    always #5 clk = ~clk;

    tx_cb_pkt_arbiter #(.DWIDTH(DW), .N_SRC(NS)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tdest  (m_tdest),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy          (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [SW-1:0] dest;
    } obeat_t;

    typedef struct {
        logic [NS-1:0] vld;
        logic [NS-1:0] exp_rdy;
        int            exp_dest;
    } vec_t;

    beat_t         src_q [NS][$];
    obeat_t        exp_q[$];
    bit            rdy_q[$];
    vec_t          tbl[10];
    int            checks = 0;
    int            errors = 0;
    int            busy_cnt, acc_cnt, del_cnt, full_seen, n;
    logic          stall_prev;
    obeat_t        held;
    logic          snap_mvld;
    logic [NS-1:0] snap_rdy;

    function automatic logic [DW-1:0] pat(input int src, input int pkt, input int idx);
        logic [7:0] b;
        b = 8'(src * 64 + pkt * 8 + idx);
        return {KW{b}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packets must be added in the order the arbiter is expected to grant them.
    task automatic add_pkt(input int src, input int pkt, input int nb);
        beat_t  b;
        obeat_t e;
        for (int i = 0; i < nb; i++) begin
            b.data = pat(src, pkt, i);
            b.last = (i == nb - 1);
            b.keep = b.last ? ({KW{1'b1}} >> (src + 1)) : {KW{1'b1}};
            src_q[src].push_back(b);
            e = {b.data, b.keep, b.last, SW'(src)};
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i]  = src_q[i][0].data;
                s_tkeep[i]  = src_q[i][0].keep;
                s_tlast[i]  = src_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i]  = '0;
                s_tkeep[i]  = '0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [NS-1:0] hs;
        obeat_t        cur, e;
        @(negedge clk);
        snap_mvld = m_tvalid;
        snap_rdy  = s_tready;
        cur       = {m_tdata, m_tkeep, m_tlast, m_tdest};
        if (busy) busy_cnt++;
        chk("rdy_onehot", 512'($countones(s_tready) <= 1), 512'(1));
        if (acc_cnt - del_cnt == 2) begin
            full_seen++;
            chk("rdy_when_full", 512'(s_tready), 512'(0));
        end
        if (stall_prev) chk("stall_stable", 512'({m_tvalid, cur}), 512'({1'b1, held}));
        stall_prev = m_tvalid && !m_tready;
        held       = cur;
        if (m_tvalid && m_tready) begin
            del_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got dest %0d, expected no beat", m_tdest);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 512'(cur), 512'(e));
            end
        end
        hs = s_tvalid & s_tready;
        acc_cnt += $countones(hs);
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive_inputs();
        if (rdy_q.size() > 0) m_tready = rdy_q.pop_front();
        else m_tready = 1'b1;
    endtask

    task automatic drain(input string name, input int budget, output int cyc);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            step();
            cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d beats outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), cyc);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        rdy_q.delete();
        drive_inputs();
        m_tready = 1'b1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        stall_prev = 1'b0;
        acc_cnt    = 0;
        del_cnt    = 0;
        busy_cnt   = 0;
        full_seen  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        release_reset();
    endtask

    initial begin
        // IDLE candidate search, single-beat packets so rr_ptr advances every accept.
        tbl[0] = '{4'b0000, 4'b0000, 0};
        tbl[1] = '{4'b0110, 4'b0010, 1};
        tbl[2] = '{4'b1001, 4'b1000, 3};
        tbl[3] = '{4'b1111, 4'b0001, 0};
        tbl[4] = '{4'b0001, 4'b0001, 0};
        tbl[5] = '{4'b1100, 4'b0100, 2};
        tbl[6] = '{4'b0111, 4'b0001, 0};
        tbl[7] = '{4'b1110, 4'b0010, 1};
        tbl[8] = '{4'b0011, 4'b0001, 0};
        tbl[9] = '{4'b1000, 4'b1000, 3};

        // Reset state with every source requesting.
        rst      = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            s_tdata[i] = pat(i, 1, 1);
            s_tkeep[i] = '1;
        end
        s_tlast  = '1;
        s_tvalid = '1;
        @(posedge clk);
        #1;
        chk("rst_m_tvalid", 512'(m_tvalid), 512'(0));
        chk("rst_m_tdata", 512'(m_tdata), 512'(0));
        chk("rst_m_tkeep_last_dest", 512'({m_tkeep, m_tlast, m_tdest}), 512'(0));
        chk("rst_s_tready", 512'(s_tready), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        clear_all();
        release_reset();

        for (int v = 0; v < 10; v++) begin
            obeat_t e;
            for (int i = 0; i < NS; i++) begin
                s_tvalid[i] = tbl[v].vld[i];
                s_tdata[i]  = pat(i, 6, v);
                s_tkeep[i]  = '1;
                s_tlast[i]  = 1'b1;
            end
            if (tbl[v].exp_rdy != '0) begin
                e = {pat(tbl[v].exp_dest, 6, v), {KW{1'b1}}, 1'b1, SW'(tbl[v].exp_dest)};
                exp_q.push_back(e);
            end
            step();
            chk("tbl_rdy", 512'(snap_rdy), 512'(tbl[v].exp_rdy));
        end
        drain("tbl", 10, n);

        // Single source, 3-beat packet.
        do_reset();
        add_pkt(0, 0, 3);
        drive_inputs();
        step();
        chk("t1_not_early", 512'(snap_mvld), 512'(0));
        chk("t1_rdy", 512'(snap_rdy), 512'(4'b0001));
        step();
        chk("t1_latency", 512'(snap_mvld), 512'(1));
        drain("t1", 20, n);
        step();
        chk("t1_busy_cycles", 512'(busy_cnt), 512'(2));

        // Contention from reset: grant order 0,1,2,3,0 without bubbles.
        do_reset();
        add_pkt(0, 0, 2);
        add_pkt(1, 0, 2);
        add_pkt(2, 0, 2);
        add_pkt(3, 0, 2);
        add_pkt(0, 1, 2);
        drive_inputs();
        drain("contend", 40, n);
        chk("contend_cycles", 512'(n), 512'(11));

        // Wrap and skip: rr_ptr=3 after a single-beat src2 packet, src1 beats src2.
        do_reset();
        add_pkt(2, 0, 1);
        drive_inputs();
        drain("wrap_pre", 10, n);
        add_pkt(1, 1, 2);
        add_pkt(2, 1, 2);
        drive_inputs();
        step();
        chk("wrap_rdy", 512'(snap_rdy), 512'(4'b0010));
        drain("wrap", 20, n);

        // Backpressure: output ready toggling during a 6-beat packet.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            rdy_q.push_back(1'b1);
            rdy_q.push_back(1'b0);
            rdy_q.push_back(1'b0);
            rdy_q.push_back(1'b1);
        end
        add_pkt(3, 0, 6);
        drive_inputs();
        drain("bp", 40, n);
        chk("bp_full_seen", 512'(full_seen > 0), 512'(1));

        // Single-beat packets from src0 and src1: alternate at full rate, never busy.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, k, 1);
            add_pkt(1, k, 1);
        end
        drive_inputs();
        drain("single", 30, n);
        chk("single_cycles", 512'(n), 512'(9));
        chk("single_busy", 512'(busy_cnt), 512'(0));

        // Async reset in the middle of a locked src3 packet with rr_ptr=3.
        do_reset();
        add_pkt(2, 0, 1);
        drive_inputs();
        drain("mid_pre", 10, n);
        add_pkt(3, 0, 4);
        drive_inputs();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_m_tvalid", 512'(m_tvalid), 512'(0));
        chk("mid_rst_m_tdata", 512'(m_tdata), 512'(0));
        chk("mid_rst_m_tkeep_last_dest", 512'({m_tkeep, m_tlast, m_tdest}), 512'(0));
        chk("mid_rst_s_tready", 512'(s_tready), 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        clear_all();
        release_reset();
        add_pkt(2, 1, 2);
        add_pkt(3, 1, 2);
        drive_inputs();
        step();
        chk("post_rst_rdy", 512'(snap_rdy), 512'(4'b0100));
        drain("post_rst", 20, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
